lo_bank: RTL and testbench

Multi-channel quadrature local-oscillator bank for the SDR AFE downconversion path. It generates N_CH independent complex LO tones, one I/Q pair per channel, from 2^ADDR_W-entry sine ROM lookups. Each channel has its own programmable frequency, phase offset and amplitude. Settings are written through a valid/ready configuration port into shadow registers, then applied to all channels on the same clock edge with an optional coherent phase reset. The bank sits between the control register file and the digital mixers.

---
 rtl/lo_bank.sv | 194 +++++++++++++++++++
 tb/tb_lo_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lo_bank.sv
// Multi-channel quadrature LO bank: shadow/active settings with an atomic commit, a
// per-channel phase accumulator and a sine-ROM -> gain -> round/saturate pipeline.
module lo_bank #(
  parameter int    N_CH          = 2,
  parameter int    WIDTH_PHASE   = 32,
  parameter int    WIDTH_NCO     = 16,
  parameter int    ADDR_W        = 14,
  parameter int    AMP_W         = 16,
  parameter string INIT_ROM_FILE = "sin_nco_14_16.mem",
  parameter int    CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      enable,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_W-1:0]           cfg_chan,
  input  logic [WIDTH_PHASE-1:0]    cfg_freq,
  input  logic [WIDTH_PHASE-1:0]    cfg_phase,
  input  logic [AMP_W-1:0]          cfg_amp,
  input  logic                      commit,
  input  logic                      commit_rst,
  output logic [N_CH*WIDTH_NCO-1:0] lo_i,
  output logic [N_CH*WIDTH_NCO-1:0] lo_q,
  output logic                      out_valid,
  output logic [N_CH-1:0]           wrap
);

  localparam int ROM_DEPTH = 1 << ADDR_W;
  localparam int QTR       = 1 << (ADDR_W - 2);
  localparam int PROD_W    = WIDTH_NCO + AMP_W + 1;
  localparam int SUM_W     = PROD_W + 1;
  localparam int HALF_LSB  = 1 << (AMP_W - 2);
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (WIDTH_NCO - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(1 << (WIDTH_NCO - 1)));

  if (ADDR_W < 4 || N_CH < 1 || N_CH > 16 || INIT_ROM_FILE == "") begin : g_param_chk
    $error("lo_bank: illegal parameterisation");
  end

  // Table is built at elaboration with the same formula that produced the image file.
  logic signed [WIDTH_NCO-1:0] rom [ROM_DEPTH];
  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    localparam real ANG = 6.283185307179586 * real'(k) / real'(ROM_DEPTH);
    localparam real VAL = real'((1 << (WIDTH_NCO - 1)) - 1) * $sin(ANG);
    localparam int  RND = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
    assign rom[k] = WIDTH_NCO'(RND);
  end

  function automatic logic signed [WIDTH_NCO-1:0] round_sat(input logic signed [PROD_W-1:0] p);
    logic signed [SUM_W-1:0] biased;
    logic signed [SUM_W-1:0] shifted;
    biased  = SUM_W'(p) + SUM_W'(HALF_LSB);
    shifted = biased >>> (AMP_W - 1);
    if (shifted > SAT_HI)      return SAT_HI[WIDTH_NCO-1:0];
    else if (shifted < SAT_LO) return SAT_LO[WIDTH_NCO-1:0];
    else                       return shifted[WIDTH_NCO-1:0];
  endfunction

  logic [WIDTH_PHASE-1:0] sh_freq  [N_CH];
  logic [WIDTH_PHASE-1:0] sh_phase [N_CH];
  logic [AMP_W-1:0]       sh_amp   [N_CH];
  logic [WIDTH_PHASE-1:0] act_freq [N_CH];
  logic [WIDTH_PHASE-1:0] act_phase[N_CH];
  logic [AMP_W-1:0]       act_amp  [N_CH];
  logic [WIDTH_PHASE-1:0] nx_freq  [N_CH];
  logic [WIDTH_PHASE-1:0] nx_phase [N_CH];
  logic [AMP_W-1:0]       nx_amp   [N_CH];
  logic                   wr_acc;
  logic                   commit_acc;
  logic                   vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;

  assign wr_acc     = cfg_valid & cfg_ready;
  assign commit_acc = commit & cfg_ready;
  assign out_valid  = vld_p4;

  // Shadow next-state includes a same-edge write so a commit picks it up immediately.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      nx_freq[c]  = sh_freq[c];
      nx_phase[c] = sh_phase[c];
      nx_amp[c]   = sh_amp[c];
      if (wr_acc && (32'(cfg_chan) == c)) begin
        nx_freq[c]  = cfg_freq;
        nx_phase[c] = cfg_phase;
        nx_amp[c]   = cfg_amp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cfg_ready <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        sh_freq[c]   <= '0;
        sh_phase[c]  <= '0;
        sh_amp[c]    <= '0;
        act_freq[c]  <= '0;
        act_phase[c] <= '0;
        act_amp[c]   <= '0;
      end
    end else begin
      cfg_ready <= ~commit_acc;
      for (int c = 0; c < N_CH; c++) begin
        sh_freq[c]  <= nx_freq[c];
        sh_phase[c] <= nx_phase[c];
        sh_amp[c]   <= nx_amp[c];
        if (commit_acc) begin
          act_freq[c]  <= nx_freq[c];
          act_phase[c] <= nx_phase[c];
          act_amp[c]   <= nx_amp[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      {vld_p0, vld_p1, vld_p2, vld_p3, vld_p4} <= '0;
    end else begin
      vld_p0 <= enable;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [WIDTH_PHASE-1:0]      acc_p0;
    logic                        wrap_p0;
    logic [WIDTH_PHASE:0]        acc_sum;
    logic [ADDR_W-1:0]           ph_top;
    logic [ADDR_W-1:0]           sin_addr_p1, cos_addr_p1;
    logic [AMP_W-1:0]            amp_p1, amp_p2;
    logic signed [WIDTH_NCO-1:0] sin_p2, cos_p2;
    logic signed [PROD_W-1:0]    sin_prod_p3, cos_prod_p3;
    logic signed [WIDTH_NCO-1:0] lo_i_p4, lo_q_p4;

    assign acc_sum = {1'b0, acc_p0} + {1'b0, act_freq[c]};
    assign ph_top  = ADDR_W'((acc_p0 + act_phase[c]) >> (WIDTH_PHASE - ADDR_W));

    // P0: phase accumulator; a reset-commit overrides enable
    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
        acc_p0  <= '0;
        wrap_p0 <= 1'b0;
      end else if (commit_acc && commit_rst) begin
        acc_p0  <= '0;
        wrap_p0 <= 1'b0;
      end else if (enable) begin
        acc_p0  <= acc_sum[WIDTH_PHASE-1:0];
        wrap_p0 <= acc_sum[WIDTH_PHASE];
      end else begin
        wrap_p0 <= 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
        sin_addr_p1 <= '0;
        cos_addr_p1 <= '0;
        amp_p1      <= '0;
        sin_p2      <= '0;
        cos_p2      <= '0;
        amp_p2      <= '0;
        sin_prod_p3 <= '0;
        cos_prod_p3 <= '0;
        lo_i_p4     <= '0;
        lo_q_p4     <= '0;
      end else begin
        // P1: phase offset, quadrature addresses; amp captured here travels with the sample
        sin_addr_p1 <= ph_top;
        cos_addr_p1 <= ph_top + ADDR_W'(QTR);
        amp_p1      <= act_amp[c];
        // P2: synchronous ROM read
        sin_p2      <= rom[sin_addr_p1];
        cos_p2      <= rom[cos_addr_p1];
        amp_p2      <= amp_p1;
        // P3: full-precision gain
        sin_prod_p3 <= PROD_W'(sin_p2) * PROD_W'($signed({1'b0, amp_p2}));
        cos_prod_p3 <= PROD_W'(cos_p2) * PROD_W'($signed({1'b0, amp_p2}));
        // P4: round half-up and saturate
        lo_i_p4     <= round_sat(cos_prod_p3);
        lo_q_p4     <= round_sat(sin_prod_p3);
      end
    end

    assign lo_i[c*WIDTH_NCO +: WIDTH_NCO] = lo_i_p4;
    assign lo_q[c*WIDTH_NCO +: WIDTH_NCO] = lo_q_p4;
    assign wrap[c]                        = wrap_p0;
  end

endmodule

// File: tb/tb_lo_bank.sv
// Scoreboard bench for lo_bank: a 2-channel instance plus a 3-channel instance (so an
// out-of-range channel index is expressible) driven from the same configuration stream.
module tb_lo_bank;

  logic        clk = 1'b0;
  logic        reset_b, enable, cfg_valid, commit, commit_rst;
  logic [0:0]  cfg_chan;
  logic [1:0]  cfg_chan3;
  logic [31:0] cfg_freq, cfg_phase;
  logic [15:0] cfg_amp;
  logic        cfg_ready, cfg_ready3, out_valid, out_valid3;
  logic [31:0] lo_i, lo_q;
  logic [47:0] lo_i3, lo_q3;
  logic [1:0]  wrap;
  logic [2:0]  wrap3;

  typedef struct { int dut; int ch; int i; int q; } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lo_bank #(.N_CH(2), .WIDTH_PHASE(32), .WIDTH_NCO(16), .ADDR_W(14), .AMP_W(16)) u_dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp),
    .commit(commit), .commit_rst(commit_rst), .lo_i(lo_i), .lo_q(lo_q),
    .out_valid(out_valid), .wrap(wrap));

  lo_bank #(.N_CH(3), .WIDTH_PHASE(32), .WIDTH_NCO(16), .ADDR_W(14), .AMP_W(16)) u_dut3 (
    .clk(clk), .reset_b(reset_b), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
    .cfg_chan(cfg_chan3), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp),
    .commit(commit), .commit_rst(commit_rst), .lo_i(lo_i3), .lo_q(lo_q3),
    .out_valid(out_valid3), .wrap(wrap3));

  function automatic int lane(input logic [47:0] v, input int ch);
    logic signed [15:0] s;
    s = v[ch*16 +: 16];
    return int'(s);
  endfunction

  function automatic int rom_model(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 16384.0);
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  function automatic int gain_model(input int r, input int amp);
    real x;
    x = $floor(real'(r) * real'(amp) / 32768.0 + 0.5);
    if (x > 32767.0)  return 32767;
    if (x < -32768.0) return -32768;
    return int'(x);
  endfunction

  task automatic cfg_cycle(input int ch, input int ch3, input logic [31:0] f, input logic [31:0] ph,
                           input logic [15:0] a, input logic wr, input logic cm, input logic cr);
    cfg_chan   = 1'(ch);
    cfg_chan3  = 2'(ch3);
    cfg_freq   = f;
    cfg_phase  = ph;
    cfg_amp    = a;
    cfg_valid  = wr;
    commit     = cm;
    commit_rst = cr;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    commit     = 1'b0;
    commit_rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_b = 1'b0; enable = 1'b0; cfg_valid = 1'b0; commit = 1'b0; commit_rst = 1'b0;
    cfg_chan = '0; cfg_chan3 = '0; cfg_freq = '0; cfg_phase = '0; cfg_amp = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (lo_i !== 32'h0) begin failures++; $display("FAIL reset_lo_i got=%h want=0", lo_i); end
    checks++; if (lo_q !== 32'h0) begin failures++; $display("FAIL reset_lo_q got=%h want=0", lo_q); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (wrap !== 2'b00) begin failures++; $display("FAIL reset_wrap got=%b want=00", wrap); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_cfg_ready got=%b want=0", cfg_ready); end
    reset_b = 1'b1;
    #2;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL release_ready_early got=%b want=0", cfg_ready); end
    @(posedge clk); #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b want=1", cfg_ready); end
  endtask

  // Channel 0 at fs/4 with a reset-commit; ipk/ineg are the required positive/negative peaks.
  task automatic test_gain(input string name, input logic [15:0] amp, input int ipk, input int ineg);
    int   pi[4];
    int   pq[4];
    exp_t e;
    pi = '{ipk, 0, ineg, 0};
    pq = '{0, ipk, 0, ineg};
    enable = 1'b1;
    cfg_cycle(0, 0, 32'h4000_0000, 32'h0, amp, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) sb.push_back('{0, 0, pi[n % 4], pq[n % 4]});
    repeat (4) @(posedge clk);
    #1;
    for (int n = 0; n < 8; n++) begin
      e = sb.pop_front();
      checks++;
      if (lane({16'h0, lo_i}, e.ch) !== e.i) begin
        failures++; $display("FAIL %s_i n=%0d got=%0d want=%0d", name, n, lane({16'h0, lo_i}, e.ch), e.i);
      end
      checks++;
      if (lane({16'h0, lo_q}, e.ch) !== e.q) begin
        failures++; $display("FAIL %s_q n=%0d got=%0d want=%0d", name, n, lane({16'h0, lo_q}, e.ch), e.q);
      end
      checks++;
      if (wrap[0] !== (n % 4 == 0)) begin
        failures++; $display("FAIL %s_wrap n=%0d got=%b want=%b", name, n, wrap[0], (n % 4 == 0));
      end
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL %s_valid n=%0d got=%b want=1", name, n, out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   sa;
    cfg_chan = 1'b1; cfg_chan3 = 2'd1;
    cfg_freq = 32'h2000_0000; cfg_phase = 32'h0; cfg_amp = 16'h8000;
    cfg_valid = 1'b1; commit = 1'b1; commit_rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low got=%b want=0", cfg_ready); end
    cfg_freq = 32'h4000_0000; cfg_amp = 16'h2000;
    @(posedge clk); #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_high got=%b want=1", cfg_ready); end
    cfg_valid = 1'b0; commit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      sa = (n * 2048) % 16384;
      sb.push_back('{0, 1, gain_model(rom_model((sa + 4096) % 16384), 32768), gain_model(rom_model(sa), 32768)});
    end
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 10; n++) begin
      e = sb.pop_front();
      checks++;
      if (lane({16'h0, lo_i}, e.ch) !== e.i) begin
        failures++; $display("FAIL b2b_i n=%0d got=%0d want=%0d", n, lane({16'h0, lo_i}, e.ch), e.i);
      end
      checks++;
      if (lane({16'h0, lo_q}, e.ch) !== e.q) begin
        failures++; $display("FAIL b2b_q n=%0d got=%0d want=%0d", n, lane({16'h0, lo_q}, e.ch), e.q);
      end
      checks++;
      if (wrap[1] !== ((n + 4) % 8 == 0)) begin
        failures++; $display("FAIL b2b_wrap n=%0d got=%b want=%b", n, wrap[1], ((n + 4) % 8 == 0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bad_chan();
    exp_t e;
    int   sa;
    int   pi[4];
    int   pq[4];
    pi = '{32767, 0, -32768, 0};
    pq = '{0, 32767, 0, -32768};
    cfg_cycle(1, 3, 32'h1234_5678, 32'h3000_0000, 16'h7000, 1'b1, 1'b1, 1'b1);
    checks++; if (cfg_ready3 !== 1'b0) begin failures++; $display("FAIL badch_ready got=%b want=0", cfg_ready3); end
    for (int n = 0; n < 8; n++) begin
      sa = (n * 2048) % 16384;
      sb.push_back('{1, 0, pi[n % 4], pq[n % 4]});
      sb.push_back('{1, 1, gain_model(rom_model((sa + 4096) % 16384), 32768), gain_model(rom_model(sa), 32768)});
      sb.push_back('{1, 2, 0, 0});
    end
    repeat (4) @(posedge clk);
    #1;
    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < 3; c++) begin
        e = sb.pop_front();
        checks++;
        if (lane(lo_i3, e.ch) !== e.i) begin
          failures++; $display("FAIL badch_i n=%0d ch=%0d got=%0d want=%0d", n, e.ch, lane(lo_i3, e.ch), e.i);
        end
        checks++;
        if (lane(lo_q3, e.ch) !== e.q) begin
          failures++; $display("FAIL badch_q n=%0d ch=%0d got=%0d want=%0d", n, e.ch, lane(lo_q3, e.ch), e.q);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    reset_b = 1'b0;
    #1;
    checks++; if (lo_i !== 32'h0) begin failures++; $display("FAIL mid_lo_i got=%h want=0", lo_i); end
    checks++; if (lo_q !== 32'h0) begin failures++; $display("FAIL mid_lo_q got=%h want=0", lo_q); end
    checks++; if (lo_i3 !== 48'h0) begin failures++; $display("FAIL mid_lo_i3 got=%h want=0", lo_i3); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b want=0", out_valid); end
    checks++; if (wrap !== 2'b00) begin failures++; $display("FAIL mid_wrap got=%b want=00", wrap); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b want=0", cfg_ready); end
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    #2;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL mid_release_early got=%b want=0", cfg_ready); end
    @(posedge clk); #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready got=%b want=1", cfg_ready); end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      checks++;
      if (lo_i !== 32'h0 || lo_q !== 32'h0) begin
        failures++; $display("FAIL mid_quiet n=%0d got_i=%h got_q=%h want=0", n, lo_i, lo_q);
      end
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_valid_back got=%b want=1", out_valid); end
  endtask

  initial begin
    test_reset();
    test_gain("unity", 16'h8000, 32767, -32767);
    test_gain("half", 16'h4000, 16384, -16383);
    test_gain("sat", 16'hFFFF, 32767, -32768);
    test_back_to_back();
    test_bad_chan();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
